// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer. The master drives the controls
// and observes the count; the timer core sits on the slave side.
interface countdown_timer_if #(
  parameter int N = 4,
  parameter int P = 8
);
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         pause;
  logic         stop;
  logic         reload;
  logic [P-1:0] tick_div;
  logic [N-1:0] count;
  logic         busy;
  logic         expired;
  logic         at_zero;

  modport master (
    output load, load_val, start, pause, stop, reload, tick_div,
    input  count, busy, expired, at_zero
  );

  modport slave (
    input  load, load_val, start, pause, stop, reload, tick_div,
    output count, busy, expired, at_zero
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with run/pause/stop control, auto-reload and a
// one-cycle expiry pulse. Optional prescaler built when COUNTDOWN_PRESCALE_EN is defined.
module countdown_timer #(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic             clk,
  input  logic             nrst,
  countdown_timer_if.slave bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         busy_q, busy_d;
  logic         expired_q, expired_d;

  logic         step_w;
  logic         presc_clr;
  logic         presc_adv;

  // Handshake: there is none; every control is a level sampled on each rising
  // edge with priority load > stop > pause > start, and all outputs except
  // at_zero are registered one cycle after the edge that sampled the control.

`ifdef COUNTDOWN_PRESCALE_EN
  logic [P-1:0] presc_q, presc_d;

  // ">=" rather than "==" so a tick_div lowered mid-run still yields a step.
  assign step_w = (presc_q >= bus.tick_div);

  always_comb begin
    presc_d = presc_q;
    if (presc_clr) begin
      presc_d = '0;
    end else if (presc_adv && (presc_q != {P{1'b1}})) begin
      presc_d = presc_q + P'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic unused_tick_div;

  assign step_w          = 1'b1;
  assign unused_tick_div = ^{bus.tick_div, presc_clr, presc_adv};
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    presc_clr = 1'b0;
    presc_adv = 1'b0;

    if (bus.load) begin
      count_d   = bus.load_val;
      reload_d  = bus.load_val;
      presc_clr = 1'b1;
      state_d   = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // stop and pause outrank start, so either one suppresses a start.
          if (bus.start && !bus.stop && !bus.pause && (count_q != '0)) begin
            state_d   = S_RUN;
            presc_clr = 1'b1;
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            state_d   = S_IDLE;
            presc_clr = 1'b1;
          end else if (bus.pause) begin
            state_d = S_PAUSED;
          end else if (step_w) begin
            presc_clr = 1'b1;
            if (count_q > N'(1)) begin
              count_d = count_q - N'(1);
            end else begin
              expired_d = 1'b1;
              if (bus.reload && (reload_q != '0)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end
          end else begin
            presc_adv = 1'b1;
          end
        end

        S_PAUSED: begin
          if (bus.stop) begin
            state_d   = S_IDLE;
            presc_clr = 1'b1;
          end else if (bus.start && !bus.pause) begin
            state_d = S_RUN;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.expired = expired_q;
  assign bus.at_zero = (count_q == '0);
  assign dbg_state_o = state_q;

`ifndef SYNTHESIS
  a_busy_matches_state: assert property (@(posedge clk) disable iff (!nrst)
    busy_q == ((state_q == S_RUN) || (state_q == S_PAUSED)));

  a_done_is_zero: assert property (@(posedge clk) disable iff (!nrst)
    (state_q == S_DONE) |-> (count_q == '0));
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer, checked cycle by cycle
// against a behavioural model of the timer's rules.
module tb_countdown_timer;

  localparam int N = 4;
  localparam int P = 8;

  logic       clk;
  logic       nrst;
  logic [1:0] dbg_state;

  countdown_timer_if #(.N(N), .P(P)) bus ();

  countdown_timer #(.N(N), .P(P)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: idle, running, paused, finished; ticks counts RUN cycles since the last step.
  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;
  mode_t m_mode;
  int    m_count;
  int    m_rel;
  int    m_ticks;
  bit    m_exp;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_count = 0;
    m_rel   = 0;
    m_ticks = 0;
    m_exp   = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit st, input bit ps,
                            input bit sp, input bit rl, input int td);
    int d;
`ifdef COUNTDOWN_PRESCALE_EN
    d = td;
`else
    d = 0;
`endif
    m_exp = 0;
    if (ld) begin
      m_count = lv;
      m_rel   = lv;
      m_ticks = 0;
      m_mode  = M_IDLE;
    end else if ((m_mode == M_RUN || m_mode == M_PAUSED) && sp) begin
      m_mode  = M_IDLE;
      m_ticks = 0;
    end else if (m_mode == M_RUN) begin
      if (ps) begin
        m_mode = M_PAUSED;
      end else if (m_ticks >= d) begin
        m_ticks = 0;
        if (m_count == 1) begin
          m_exp = 1;
          if (rl) m_count = m_rel;
          else begin
            m_count = 0;
            m_mode  = M_DONE;
          end
        end else begin
          m_count = m_count - 1;
        end
      end else if (m_ticks < (1 << P) - 1) begin
        m_ticks = m_ticks + 1;
      end
    end else if (m_mode == M_PAUSED) begin
      if (st && !ps) m_mode = M_RUN;
    end else if (m_mode == M_IDLE) begin
      if (st && !ps && !sp && m_count != 0) begin
        m_mode  = M_RUN;
        m_ticks = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("count",   32'(bus.count),   32'(m_count));
    check_val("busy",    32'(bus.busy),    32'(m_mode == M_RUN || m_mode == M_PAUSED));
    check_val("expired", 32'(bus.expired), 32'(m_exp));
    check_val("at_zero", 32'(bus.at_zero), 32'(m_count == 0));
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit ld, input int lv, input bit st, input bit ps,
                             input bit sp, input bit rl, input int td);
    bus.load     = ld;
    bus.load_val = N'(lv);
    bus.start    = st;
    bus.pause    = ps;
    bus.stop     = sp;
    bus.reload   = rl;
    bus.tick_div = P'(td);
    model_step(ld, lv, st, ps, sp, rl, td);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n, input bit rl, input int td);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, rl, td);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    bus.load = 0; bus.load_val = '0; bus.start = 0; bus.pause = 0;
    bus.stop = 0; bus.reload = 0; bus.tick_div = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check_val("rst_count",   32'(bus.count),   32'd0);
    check_val("rst_busy",    32'(bus.busy),    32'd0);
    check_val("rst_expired", 32'(bus.expired), 32'd0);
    check_val("rst_at_zero", 32'(bus.at_zero), 32'd1);

    // 3,2,1,0 at D=0, then start ignored in DONE
    drive_cycle(1, 3, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0, 0);
    idle_cycles(4, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0, 0);
    idle_cycles(2, 0, 0);

    // prescaled run, D=2
    drive_cycle(1, 2, 0, 0, 0, 0, 2);
    drive_cycle(0, 0, 1, 0, 0, 0, 2);
    idle_cycles(8, 0, 2);

    // auto-reload of 2 at D=0
    drive_cycle(1, 2, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 1, 0, 0, 1, 0);
    idle_cycles(9, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 1, 0);

    // pause mid-prescale at D=3, resume, then start+pause together
    drive_cycle(1, 9, 0, 0, 0, 0, 3);
    drive_cycle(0, 0, 1, 0, 0, 0, 3);
    idle_cycles(1, 0, 3);
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, 1, 0, 0, 3);
    drive_cycle(0, 0, 1, 0, 0, 0, 3);
    idle_cycles(5, 0, 3);
    drive_cycle(0, 0, 1, 1, 0, 0, 3);
    idle_cycles(2, 0, 3);

    // zero load, stop/resume, load during RUN
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0, 0);
    idle_cycles(3, 0, 0);
    drive_cycle(1, 8, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0, 0);
    idle_cycles(3, 0, 0);
    drive_cycle(0, 0, 0, 0, 1, 0, 0);
    idle_cycles(2, 0, 0);
    check_val("stop_holds", 32'(bus.count), 32'd5);
    drive_cycle(0, 0, 1, 0, 0, 0, 0);
    idle_cycles(2, 0, 0);
    drive_cycle(1, 11, 0, 0, 0, 0, 0);
    idle_cycles(2, 0, 0);

    // asynchronous reset mid-RUN at count 7
    drive_cycle(1, 9, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0, 0);
    idle_cycles(2, 0, 0);
    check_val("pre_rst_count", 32'(bus.count), 32'd7);
    #2;
    nrst = 1'b0;
    #1;
    check_val("arst_count",   32'(bus.count),   32'd0);
    check_val("arst_busy",    32'(bus.busy),    32'd0);
    check_val("arst_expired", 32'(bus.expired), 32'd0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // randomized phase
    begin
      bit rl;
      int td;
      rl = 0;
      td = 0;
      for (int i = 0; i < 600; i++) begin
        bit ld, st, ps, sp;
        int lv;
        ld = ($urandom_range(0, 99) < 6);
        st = ($urandom_range(0, 99) < 20);
        ps = ($urandom_range(0, 99) < 8);
        sp = ($urandom_range(0, 99) < 4);
        lv = $urandom_range(0, (1 << N) - 1);
        if ($urandom_range(0, 99) < 5) rl = ~rl;
        if ($urandom_range(0, 99) < 5) td = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
        drive_cycle(ld, lv, st, ps, sp, rl, td);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
